// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL test harness blocks.
// Holds the reference generator state encoding and its fixed limits.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ref_state_e;

    localparam int unsigned MIN_REF_PERIOD = 2;
    localparam int unsigned EDGE_CNT_WIDTH = 16;

endpackage

// File: rtl/ref_period_calc.sv
// Combinational period calculator: fractional carry, one-shot step, clamp,
// and the high/low split of the resulting reference period.
module ref_period_calc
    import adpll_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH   = 8,
    parameter int unsigned STEP_WIDTH   = 8
) (
    input  logic [PERIOD_WIDTH-1:0]      i_period,
    input  logic [FRAC_WIDTH-1:0]        i_frac,
    input  logic [FRAC_WIDTH-1:0]        i_acc,
    input  logic signed [STEP_WIDTH-1:0] i_step,
    output logic [FRAC_WIDTH-1:0]        o_acc_next,
    output logic [PERIOD_WIDTH-1:0]      o_high_len,
    output logic [PERIOD_WIDTH-1:0]      o_low_len
);

    localparam int unsigned SUM_WIDTH = PERIOD_WIDTH + 2;
    localparam logic signed [SUM_WIDTH-1:0] P_MIN = SUM_WIDTH'(MIN_REF_PERIOD);
    localparam logic signed [SUM_WIDTH-1:0] P_MAX = {2'b00, {PERIOD_WIDTH{1'b1}}};

    logic [FRAC_WIDTH:0]         w_frac_sum;
    logic signed [SUM_WIDTH-1:0] w_period_ext;
    logic signed [SUM_WIDTH-1:0] w_carry_ext;
    logic signed [SUM_WIDTH-1:0] w_step_ext;
    logic signed [SUM_WIDTH-1:0] w_p;
    logic [PERIOD_WIDTH-1:0]     w_p_clamp;

    // Accumulator wraps at 2^FRAC_WIDTH; the overflow bit is the carry.
    assign w_frac_sum   = {1'b0, i_acc} + {1'b0, i_frac};
    assign o_acc_next   = w_frac_sum[FRAC_WIDTH-1:0];

    assign w_period_ext = {2'b00, i_period};
    assign w_carry_ext  = SUM_WIDTH'(w_frac_sum[FRAC_WIDTH]);
    assign w_step_ext   = {{(SUM_WIDTH-STEP_WIDTH){i_step[STEP_WIDTH-1]}}, i_step};
    assign w_p          = w_period_ext + w_carry_ext + w_step_ext;

    always_comb begin
        w_p_clamp = w_p[PERIOD_WIDTH-1:0];
        if (w_p < P_MIN) begin
            w_p_clamp = PERIOD_WIDTH'(MIN_REF_PERIOD);
        end else if (w_p > P_MAX) begin
            w_p_clamp = {PERIOD_WIDTH{1'b1}};
        end
    end

    // Odd periods put the extra cycle in the low phase.
    assign o_high_len = w_p_clamp >> 1;
    assign o_low_len  = w_p_clamp - o_high_len;

endmodule

// File: rtl/ref_clk_gen.sv
// Programmable reference-clock transmitter: integer+fractional period,
// run/stop and one-shot phase steps, with edges only at period boundaries.
module ref_clk_gen
    import adpll_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH   = 8,
    parameter int unsigned STEP_WIDTH   = 8,
    parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = PERIOD_WIDTH'(8)
) (
    input  logic                        fpga_clk_i,
    input  logic                        reset_n_i,
    input  logic                        enable_i,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [PERIOD_WIDTH-1:0]     cfg_period_i,
    input  logic [FRAC_WIDTH-1:0]       cfg_frac_i,
    input  logic                        step_valid_i,
    output logic                        step_ready_o,
    input  logic signed [STEP_WIDTH-1:0] step_i,
    output logic                        ref_clk_o,
    output logic                        edge_o,
    output logic                        running_o,
    output logic [EDGE_CNT_WIDTH-1:0]   edge_count_o
);

    localparam logic [PERIOD_WIDTH-1:0]   CNT_ONE    = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0]   PERIOD_MIN = PERIOD_WIDTH'(MIN_REF_PERIOD);
    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_ONE   = EDGE_CNT_WIDTH'(1);

    ref_state_e                   r_state;
    logic [PERIOD_WIDTH-1:0]      r_cnt;
    logic [PERIOD_WIDTH-1:0]      r_low_len;
    logic [PERIOD_WIDTH-1:0]      r_period;
    logic [FRAC_WIDTH-1:0]        r_frac;
    logic [FRAC_WIDTH-1:0]        r_acc;
    logic [PERIOD_WIDTH-1:0]      r_cfg_period;
    logic [FRAC_WIDTH-1:0]        r_cfg_frac;
    logic                         r_cfg_ready;
    logic signed [STEP_WIDTH-1:0] r_step;
    logic                         r_step_ready;
    logic                         r_ref_clk;
    logic                         r_edge;
    logic                         r_running;
    logic [EDGE_CNT_WIDTH-1:0]    r_edge_cnt;

    logic                         w_cfg_pending;
    logic                         w_step_pending;
    logic                         w_cfg_accept;
    logic                         w_step_accept;
    logic                         w_period_end;
    logic                         w_boundary;
    logic [PERIOD_WIDTH-1:0]      w_cfg_period_min;
    logic [PERIOD_WIDTH-1:0]      w_calc_period;
    logic [FRAC_WIDTH-1:0]        w_calc_frac;
    logic [FRAC_WIDTH-1:0]        w_calc_acc;
    logic signed [STEP_WIDTH-1:0] w_calc_step;
    logic [FRAC_WIDTH-1:0]        w_acc_next;
    logic [PERIOD_WIDTH-1:0]      w_high_len;
    logic [PERIOD_WIDTH-1:0]      w_low_len;

    assign w_cfg_pending    = ~r_cfg_ready;
    assign w_step_pending   = ~r_step_ready;
    assign w_cfg_accept     = cfg_valid_i & r_cfg_ready;
    assign w_step_accept    = step_valid_i & r_step_ready;
    assign w_cfg_period_min = (cfg_period_i < PERIOD_MIN) ? PERIOD_MIN : cfg_period_i;

    assign w_period_end = (r_state == ST_LOW) && (r_cnt == '0);
    assign w_boundary   = enable_i && ((r_state == ST_IDLE) || w_period_end);

    // A pending config replaces the live one and restarts the fractional phase.
    assign w_calc_period = w_cfg_pending  ? r_cfg_period : r_period;
    assign w_calc_frac   = w_cfg_pending  ? r_cfg_frac   : r_frac;
    assign w_calc_acc    = w_cfg_pending  ? '0           : r_acc;
    assign w_calc_step   = w_step_pending ? r_step       : '0;

    ref_period_calc #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .FRAC_WIDTH   (FRAC_WIDTH),
        .STEP_WIDTH   (STEP_WIDTH)
    ) u_period_calc (
        .i_period   (w_calc_period),
        .i_frac     (w_calc_frac),
        .i_acc      (w_calc_acc),
        .i_step     (w_calc_step),
        .o_acc_next (w_acc_next),
        .o_high_len (w_high_len),
        .o_low_len  (w_low_len)
    );

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_low_len    <= '0;
            r_period     <= DEFAULT_PERIOD;
            r_frac       <= '0;
            r_acc        <= '0;
            r_cfg_period <= '0;
            r_cfg_frac   <= '0;
            r_cfg_ready  <= 1'b1;
            r_step       <= '0;
            r_step_ready <= 1'b1;
            r_ref_clk    <= 1'b0;
            r_edge       <= 1'b0;
            r_running    <= 1'b0;
            r_edge_cnt   <= '0;
        end else begin
            r_edge <= 1'b0;

            if (w_cfg_accept) begin
                r_cfg_period <= w_cfg_period_min;
                r_cfg_frac   <= cfg_frac_i;
                r_cfg_ready  <= 1'b0;
            end
            if (w_step_accept) begin
                r_step       <= step_i;
                r_step_ready <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_pending) begin
                        r_period    <= r_cfg_period;
                        r_frac      <= r_cfg_frac;
                        r_acc       <= '0;
                        r_cfg_ready <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_LOW;
                        r_ref_clk <= 1'b0;
                        r_cnt     <= r_low_len - CNT_ONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Period boundary: start a new high phase, consume pending slots.
            if (w_boundary) begin
                r_state    <= ST_HIGH;
                r_ref_clk  <= 1'b1;
                r_edge     <= 1'b1;
                r_running  <= 1'b1;
                r_edge_cnt <= r_edge_cnt + EDGE_ONE;
                r_cnt      <= w_high_len - CNT_ONE;
                r_low_len  <= w_low_len;
                r_acc      <= w_acc_next;
                if (w_cfg_pending) begin
                    r_period    <= r_cfg_period;
                    r_frac      <= r_cfg_frac;
                    r_cfg_ready <= 1'b1;
                end
                if (w_step_pending) begin
                    r_step_ready <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready_o  = r_cfg_ready;
    assign step_ready_o = r_step_ready;
    assign ref_clk_o    = r_ref_clk;
    assign edge_o       = r_edge;
    assign running_o    = r_running;
    assign edge_count_o = r_edge_cnt;

endmodule

// File: doc/ref_clk_gen.md
# ref_clk_gen

Programmable reference-clock transmitter for the ADPLL test harness. It runs on `fpga_clk_i` and generates the `ref_clk` square wave that the PLL's phase detector receives. The integer-plus-fractional period, run/stop control and one-shot phase steps are controlled from registers, which gives the bench a known, steerable reference for locking the loop and measuring its response. Output edges change only at period boundaries, so the PLL never sees a runt pulse.

## Interface
- `PERIOD_WIDTH`, default 16: width of the integer period, counted in `fpga_clk_i` cycles.
- `FRAC_WIDTH`, default 8: width of the fractional period accumulator.
- `STEP_WIDTH`, default 8: width of the signed one-shot phase step.
- `DEFAULT_PERIOD`, default 16'd8: integer period after reset.

- `fpga_clk_i`  in  1: the only clock.
- `reset_n_i`  in  1: reset, synchronous and active-low.
- `enable_i`  in  1: run request. Sampled in IDLE and at every period end.
- `cfg_valid_i`  in  1: a new period is offered.
- `cfg_ready_o`  out  1: the config slot is free.
- `cfg_period_i`  in  PERIOD_WIDTH: integer period. Values below 2 are treated as 2.
- `cfg_frac_i`  in  FRAC_WIDTH: fractional increment per period.
- `step_valid_i`  in  1: a phase step is offered.
- `step_ready_o`  out  1: the step slot is free.
- `step_i`  in  STEP_WIDTH (signed): cycles added to exactly one period.
- `ref_clk_o`  out  1: the generated reference clock (registered).
- `edge_o`  out  1: one-cycle pulse, coincident with each rising edge of `ref_clk_o`.
- `running_o`  out  1: high while not in IDLE.
- `edge_count_o`  out  16: count of rising edges, wraps modulo 2^16.

## Operation
- **States:**
  - IDLE: `ref_clk_o` = 0.
  - HIGH: `ref_clk_o` = 1.
  - LOW: `ref_clk_o` = 0.
- **Period calculation (at each boundary):**
  - P = period_reg + carry + pending_step.
  - carry comes from `frac_acc` + frac_reg, which wraps at 2^FRAC_WIDTH.
  - P is computed in PERIOD_WIDTH+2 bits signed, then clamped to the range [2, 2^PERIOD_WIDTH − 1].
  - high_len = floor(P/2); low_len = P − high_len.
- **Transitions:**
  - IDLE → HIGH: when `enable_i` = 1 at a clock edge. The calculation is performed on entry.
  - HIGH → LOW: after high_len cycles in HIGH.
  - LOW → HIGH: after low_len cycles in LOW, when `enable_i` = 1. The next P is calculated on this transition.
  - LOW → IDLE: after low_len cycles in LOW, when `enable_i` = 0.
  - Deasserting `enable_i` mid-period never truncates the period.
- **Config handshake:**
  - A config is accepted when `cfg_valid_i` & `cfg_ready_o`; it is stored as pending and `cfg_ready_o` drops.
  - The pending config is applied at the next period calculation, or in the next cycle if in IDLE.
  - On apply: period_reg and frac_reg are loaded, `frac_acc` is cleared, and `cfg_ready_o` rises the following cycle.
  - Apply and a new accept in the same cycle: apply wins; the new offer is accepted one cycle later.
- **Step handshake:**
  - A step is accepted when `step_valid_i` & `step_ready_o`, into a single slot.
  - The step is consumed by the next period calculation, then the slot is cleared.
  - A step accepted while in IDLE applies to the first period after the block starts.
- **Simultaneous config and step at a boundary:** both are applied. The step adds to the new period, and carry is 0 because `frac_acc` was just cleared.
- **Reset:**
  - `reset_n_i` = 0 at any point, including mid-period: next state IDLE.
  - All outputs and registers go to: `ref_clk_o` 0, `edge_o` 0, `running_o` 0, `edge_count_o` 0.
  - `cfg_ready_o` 1, `step_ready_o` 1 (both slots empty).
  - period_reg = DEFAULT_PERIOD, frac_reg 0, `frac_acc` 0.

## Timing
- **Start latency:** `enable_i` sampled 1 in IDLE at edge n → `ref_clk_o` = 1 and `edge_o` = 1 after edge n (registered, 1 cycle).
- **Period:** consecutive `edge_o` pulses are exactly P cycles apart.
- **`edge_count_o`:** increments in the same cycle as `edge_o`; 0xFFFF wraps to 0x0000.
- **Config apply latency:** a config accepted ≥1 cycle before a boundary affects the period that starts at that boundary. If it is accepted in the boundary cycle itself, it takes effect one boundary later.
- **Ready outputs:** both `*_ready_o` are registered and never combinationally dependent on `*_valid_i`.
- **`running_o`:** rises with the first `ref_clk_o` edge and falls the cycle after the last LOW cycle.

## Structure
- **Shared package `adpll_pkg`:**
  - State enum: IDLE, HIGH, LOW.
  - `MIN_REF_PERIOD` = 2.
  - Edge-counter width = 16.
- **Sub-module `ref_period_calc`:** combinational. Inputs: period_reg, frac_reg, `frac_acc`, step. Outputs: next `frac_acc`, high_len, low_len, after the clamp and split.
- **Top level:** the FSM, down-counter, both handshake slots and the edge counter.

## Test plan
- Reset with default config, `enable_i` = 1: `ref_clk_o` runs 4 cycles high, 4 low; `edge_count_o` = 10 after 10 edges.
- Config period 10, frac 0x80: periods measure 10, 11, 10, 11, … (mean 10.5); periods 3 and 5 have high/low split 1/2 and 2/3.
- Period 8, step −3 accepted mid-period: exactly one period of 5 (high 2, low 3), then periods of 8; `step_ready_o` returns to 1 after consumption.
- Period 8, step −10: clamped to one period of 2; config period 0: periods of 2.
- `enable_i` dropped 1 cycle after a rising edge (period 8): the period completes, the block enters IDLE, and `running_o` falls; re-enabling gives the first edge 1 cycle later.
- `reset_n_i` low in the middle of HIGH with a config pending: outputs go to their reset values, `cfg_ready_o` = 1, and the period returns to 8 on restart.
